burst_pack_fifo: RTL

Parametrised burst buffer for the burst interface datapath. It accepts single beats on a valid/ready input stream and stores them in a DEPTH-entry FIFO. It emits them as fixed-length bursts of BURST_LEN beats, with a last-beat marker, on a valid/ready output. A flush request drains residual data as a short final burst. It sits between a beat producer and a burst-oriented consumer.

---
 rtl/burst_pack_fifo.sv | 114 +++++++++++
 1 files changed

// File: rtl/burst_pack_fifo.sv
// Beat FIFO that replays stored data as fixed-length bursts (short final burst on flush); out_valid rises 2 cycles after the completing push.
// Input backpressure via in_ready when full; output beats may be stalled indefinitely by out_ready without ending the burst.
module burst_pack_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int BURST_LEN = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_last,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] BL    = LW'(BURST_LEN);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  typedef enum logic {IDLE, BURST} state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level_nxt;
  logic [LW-1:0]     burst_len, burst_len_nxt;
  logic [LW-1:0]     beat_cnt, beat_cnt_nxt;
  logic              flush_pend, flush_pend_nxt;
  state_t            state, state_nxt;
  logic              push, pop;

  assign in_ready  = (level < DEPTH_L);
  assign out_valid = (state == BURST);
  assign out_last  = out_valid && (beat_cnt == burst_len - LW'(1));
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
  end

  // Emptying pop wins over a same-cycle flush: nothing is left to drain.
  always_comb begin
    flush_pend_nxt = flush_pend;
    if (flush && (level != '0 || state == BURST))
      flush_pend_nxt = 1'b1;
    if (pop && level_nxt == '0)
      flush_pend_nxt = 1'b0;
  end

  always_comb begin
    state_nxt     = state;
    burst_len_nxt = burst_len;
    beat_cnt_nxt  = beat_cnt;
    case (state)
      IDLE: begin
        if (level >= BL || (flush_pend && level != '0)) begin
          state_nxt     = BURST;
          burst_len_nxt = (level >= BL) ? BL : level;
          beat_cnt_nxt  = '0;
        end
      end
      BURST: begin
        if (pop) begin
          if (out_last)
            state_nxt = IDLE;
          else
            beat_cnt_nxt = beat_cnt + LW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      level      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      flush_pend <= 1'b0;
      burst_len  <= '0;
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      level      <= level_nxt;
      flush_pend <= flush_pend_nxt;
      burst_len  <= burst_len_nxt;
      beat_cnt   <= beat_cnt_nxt;
      if (push)
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= in_data;
  end

endmodule
